// File: rtl/constants_pkg.sv
// Shared constants and types for the instruction cache and its line-fill bus.
package constants_pkg;
  localparam int ICLLEN       = 128;
  localparam int ICACHE_LINES = 4;

  typedef enum logic {IDLE, MISS} icache_state_t;
endpackage

// File: rtl/instruction_bus.sv
// Line-fill handshake between the instruction cache and the memory side.
interface instruction_bus;
  import constants_pkg::*;

  logic              ldp;
  logic [31:0]       ldAddr;
  logic              ldr;
  logic [ICLLEN-1:0] ldData;

  modport consumer (output ldp, output ldAddr, input ldr, input ldData);
  modport producer (input ldp, input ldAddr, output ldr, output ldData);
endinterface

// File: rtl/icache_array.sv
// Direct-mapped tag/data/valid storage: one write port, asynchronous read.
module icache_array
  import constants_pkg::*;
#(
  parameter int NLINES = ICACHE_LINES,
  parameter int IW     = 2,
  parameter int TW     = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [TW-1:0]     wtag,
  input  logic [ICLLEN-1:0] wdata,
  input  logic [IW-1:0]     raddr,
  output logic              rvalid,
  output logic [TW-1:0]     rtag,
  output logic [ICLLEN-1:0] rdata
);
  logic [NLINES-1:0] valid;
  logic [TW-1:0]     tags  [NLINES];
  logic [ICLLEN-1:0] lines [NLINES];

  // Clear has priority so a flush coinciding with a fill leaves that line invalid.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= '0;
    end else if (we) begin
      valid[waddr] <= 1'b1;
    end
  end

  // NOTE: storage arrays carry no reset; the valid bits alone decide whether contents are used.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[waddr]  <= wtag;
      lines[waddr] <= wdata;
    end
  end

  assign rvalid = valid[raddr];
  assign rtag   = tags[raddr];
  assign rdata  = lines[raddr];
endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: combinational hit path, blocking line fill on a miss.
module icache
  import constants_pkg::*;
#(
  parameter int NLINES = ICACHE_LINES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [31:0] rsp_instr,
  output logic        stall,
  instruction_bus.consumer bus
);
  localparam int IW = $clog2(NLINES);
  localparam int TW = 28 - IW;

  icache_state_t state;
  logic          flush_pend;
  logic          ldp_q;
  logic [31:0]   miss_addr;

  logic [IW-1:0]     req_index;
  logic [TW-1:0]     req_tag;
  logic [1:0]        req_word;
  logic              arr_valid;
  logic [TW-1:0]     arr_tag;
  logic [ICLLEN-1:0] arr_data;
  logic              hit;
  logic              fill;
  logic              clear;
  logic              unused_addr_bits;

  assign req_index        = req_addr[4 +: IW];
  assign req_tag          = req_addr[31 -: TW];
  assign req_word         = req_addr[3:2];
  assign unused_addr_bits = ^req_addr[1:0];

  assign hit   = arr_valid && (arr_tag == req_tag);
  assign fill  = (state == MISS) && bus.ldr && !rst;
  assign clear = !rst && (((state == IDLE) && flush) || (fill && (flush_pend || flush)));

  // Fill index and tag come from the latched line address, not the live request.
  icache_array #(
    .NLINES (NLINES),
    .IW     (IW),
    .TW     (TW)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .we     (fill),
    .waddr  (miss_addr[4 +: IW]),
    .wtag   (miss_addr[31 -: TW]),
    .wdata  (bus.ldData),
    .raddr  (req_index),
    .rvalid (arr_valid),
    .rtag   (arr_tag),
    .rdata  (arr_data)
  );

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_instr = '0;
    stall     = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (!flush && req_valid) begin
            if (hit) begin
              rsp_valid = 1'b1;
              rsp_instr = arr_data[{req_word, 5'b0} +: 32];
            end else begin
              stall = 1'b1;
            end
          end
        end
        MISS:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      ldp_q      <= 1'b0;
      miss_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush && req_valid && !hit) begin
            miss_addr <= {req_addr[31:4], 4'b0};
            ldp_q     <= 1'b1;
            state     <= MISS;
          end
        end
        MISS: begin
          if (bus.ldr) begin
            ldp_q      <= 1'b0;
            flush_pend <= 1'b0;
            state      <= IDLE;
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset masks the fill request immediately rather than one edge later.
  assign bus.ldp    = ldp_q & ~rst;
  assign bus.ldAddr = miss_addr;
endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: fills, hits, conflicts, flushes, reset mid-miss.
module tb_icache;
  import constants_pkg::*;

  localparam logic [ICLLEN-1:0] LINE0 = 128'h00408093_00308093_00208093_00108093;
  localparam logic [ICLLEN-1:0] LINE1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [ICLLEN-1:0] LINE2 = 128'hdddd0003_cccc0002_bbbb0001_aaaa0000;
  localparam logic [ICLLEN-1:0] JUNK  = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic        stall;

  int checks = 0;
  int errors = 0;

  instruction_bus bus_if ();

  icache #(.NLINES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_instr (rsp_instr),
    .stall     (stall),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic next();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_miss_cycle(input string tag, input logic exp_ldp, input logic [31:0] exp_addr);
    chk({tag, "_stall"}, {31'b0, stall}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_instr"}, rsp_instr, 32'd0);
    chk({tag, "_ldp"}, {31'b0, bus_if.ldp}, {31'b0, exp_ldp});
    if (exp_ldp) chk({tag, "_ldAddr"}, bus_if.ldAddr, exp_addr);
  endtask

  task automatic expect_hit(input string tag, input logic [31:0] exp_instr);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
    chk({tag, "_ldp"}, {31'b0, bus_if.ldp}, 32'd0);
    chk({tag, "_rsp_instr"}, rsp_instr, exp_instr);
  endtask

  task automatic expect_quiet(input string tag);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
    chk({tag, "_ldp"}, {31'b0, bus_if.ldp}, 32'd0);
    chk({tag, "_rsp_instr"}, rsp_instr, 32'd0);
  endtask

  initial begin
    bus_if.ldr    = 1'b0;
    bus_if.ldData = '0;

    // Reset: outputs quiet during and after.
    next(); settle();
    expect_quiet("reset_during");
    next(); rst = 1'b0; settle();
    expect_quiet("reset_after");

    // Cold miss on 0x8, memory answers in the first MISS cycle.
    req_valid = 1'b1; req_addr = 32'h0000_0008; settle();
    expect_miss_cycle("cold_idle", 1'b0, 32'h0);
    next(); bus_if.ldr = 1'b1; bus_if.ldData = LINE0; settle();
    expect_miss_cycle("cold_miss", 1'b1, 32'h0000_0000);
    next(); bus_if.ldr = 1'b0; settle();
    expect_hit("cold_hit", 32'h0030_8093);

    // Hits on the rest of the filled line.
    next(); req_addr = 32'h0000_0000; settle();
    expect_hit("hit_w0", 32'h0010_8093);
    next(); req_addr = 32'h0000_0004; settle();
    expect_hit("hit_w1", 32'h0020_8093);
    next(); req_addr = 32'h0000_000C; settle();
    expect_hit("hit_w3", 32'h0040_8093);

    // Idle with ldr asserted: ignored, line 0 keeps its contents.
    next(); req_valid = 1'b0; bus_if.ldr = 1'b1; bus_if.ldData = JUNK; settle();
    expect_quiet("idle_ldr");
    next(); bus_if.ldr = 1'b0; req_valid = 1'b1; req_addr = 32'h0000_0000; settle();
    expect_hit("idle_ldr_nowrite", 32'h0010_8093);

    // Conflict on index 0 with delayed memory (ldr withheld 5 cycles).
    next(); req_addr = 32'h0000_0040; settle();
    expect_miss_cycle("conflict_idle", 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      next(); settle();
      expect_miss_cycle("delay_wait", 1'b1, 32'h0000_0040);
    end
    next(); bus_if.ldr = 1'b1; bus_if.ldData = LINE1; settle();
    expect_miss_cycle("delay_fill", 1'b1, 32'h0000_0040);
    next(); bus_if.ldr = 1'b0; settle();
    expect_hit("conflict_hit", 32'h1111_1111);

    // The evicted line at 0x0 now misses and is refetched.
    next(); req_addr = 32'h0000_0000; settle();
    expect_miss_cycle("evicted_idle", 1'b0, 32'h0);
    next(); bus_if.ldr = 1'b1; bus_if.ldData = LINE0; settle();
    expect_miss_cycle("evicted_miss", 1'b1, 32'h0000_0000);
    next(); bus_if.ldr = 1'b0; settle();
    expect_hit("evicted_hit", 32'h0010_8093);

    // Flush in IDLE with a would-be hit: quiet that cycle, then a miss.
    next(); flush = 1'b1; settle();
    expect_quiet("flush_idle");
    next(); flush = 1'b0; settle();
    expect_miss_cycle("after_flush", 1'b0, 32'h0);
    next(); bus_if.ldr = 1'b1; bus_if.ldData = LINE0; settle();
    expect_miss_cycle("after_flush_miss", 1'b1, 32'h0000_0000);
    next(); bus_if.ldr = 1'b0; settle();
    expect_hit("after_flush_hit", 32'h0010_8093);

    // Flush during MISS: the filled line is dropped and the held request misses again.
    next(); req_addr = 32'h0000_0010; settle();
    expect_miss_cycle("pend_idle", 1'b0, 32'h0);
    next(); flush = 1'b1; settle();
    expect_miss_cycle("pend_flush", 1'b1, 32'h0000_0010);
    next(); flush = 1'b0; bus_if.ldr = 1'b1; bus_if.ldData = LINE2; settle();
    expect_miss_cycle("pend_fill", 1'b1, 32'h0000_0010);
    next(); bus_if.ldr = 1'b0; settle();
    expect_miss_cycle("pend_remiss", 1'b0, 32'h0);
    next(); bus_if.ldr = 1'b1; settle();
    expect_miss_cycle("pend_refill", 1'b1, 32'h0000_0010);
    next(); bus_if.ldr = 1'b0; settle();
    expect_hit("pend_hit", 32'haaaa_0000);
    next(); req_addr = 32'h0000_0000; settle();
    expect_miss_cycle("pend_cleared_other", 1'b0, 32'h0);
    next(); bus_if.ldr = 1'b1; bus_if.ldData = LINE0; settle();
    next(); bus_if.ldr = 1'b0; settle();
    expect_hit("pend_other_refill", 32'h0010_8093);

    // Reset mid-miss: fill abandoned, late ldr ignored, lines invalid afterwards.
    next(); req_addr = 32'h0000_0020; settle();
    expect_miss_cycle("rstmiss_idle", 1'b0, 32'h0);
    next(); settle();
    expect_miss_cycle("rstmiss_miss", 1'b1, 32'h0000_0020);
    next(); rst = 1'b1; req_valid = 1'b0; settle();
    expect_quiet("rstmiss_during");
    next(); rst = 1'b0; bus_if.ldr = 1'b1; bus_if.ldData = JUNK; settle();
    expect_quiet("rstmiss_late_ldr");
    chk("rstmiss_ldAddr_cleared", bus_if.ldAddr, 32'h0);
    next(); bus_if.ldr = 1'b0; req_valid = 1'b1; req_addr = 32'h0000_0020; settle();
    expect_miss_cycle("rstmiss_again", 1'b0, 32'h0);
    next(); settle();
    expect_miss_cycle("rstmiss_again_miss", 1'b1, 32'h0000_0020);
    next(); bus_if.ldr = 1'b1; bus_if.ldData = LINE2; settle();
    next(); bus_if.ldr = 1'b0; req_addr = 32'h0000_0028; settle();
    expect_hit("rstmiss_refill_hit", 32'hcccc_0002);
    next(); req_addr = 32'h0000_0000; settle();
    expect_miss_cycle("rstmiss_line0_invalid", 1'b0, 32'h0);

    next(); req_valid = 1'b0; rst = 1'b1;
    next();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
